// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate controller.
package parking_pkg;

    localparam int unsigned FLOOR_CAP           = 500;
    localparam int unsigned TOTAL_CAP           = 1000;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned OPEN_TIMEOUT_DEF    = 1000;
    localparam int unsigned TMO_W               = 10;
    localparam int unsigned NUM_SENSORS         = 5;

    typedef enum logic [2:0] {
        E_IDLE,
        E_CHECK,
        E_OPEN,
        E_PASS,
        E_DENY
    } entry_state_e;

    typedef enum logic [1:0] {
        X_IDLE,
        X_OPEN,
        X_PASS
    } exit_state_e;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a stable-level filter: the output follows
// the input only after CYCLES consecutive identical synchronized samples.
module sensor_debounce
    import parking_pkg::*;
#(
    parameter int unsigned CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], async_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // Any sample agreeing with the accepted level restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(CYCLES - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/parking_gate.sv
// Entry/exit barrier controller with occupancy event pulse scheduler.
// Optional open-barrier timeout enabled by PARKING_GATE_TIMEOUT_EN.
module parking_gate
    import parking_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned OPEN_TIMEOUT    = OPEN_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic car_arrive,
    input  logic entry_passed,
    input  logic exit0_req,
    input  logic exit1_req,
    input  logic exit_passed,
    input  logic full,
    input  logic floor0,
    input  logic floor1,
    output logic in,
    output logic out0,
    output logic out1,
    output logic entry_open,
    output logic exit_open,
    output logic route_floor,
    output logic denied
);

    logic [NUM_SENSORS-1:0] raw, deb;
    logic car_db, epass_db, x0_db, x1_db, xpass_db;

    assign raw = {exit_passed, exit1_req, exit0_req, entry_passed, car_arrive};

    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_deb
        sensor_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk     (clk),
            .rst     (rst),
            .async_i (raw[g]),
            .level_o (deb[g])
        );
    end

    assign {xpass_db, x1_db, x0_db, epass_db, car_db} = deb;

    entry_state_e e_state_q, e_state_d;
    exit_state_e  x_state_q, x_state_d;
    logic x_floor_q, x_floor_d, rr_q, rr_d;
    logic in_req_c, out_req_c;
    logic in_pend_q, in_pend_d, out_pend_q, out_pend_d, out_fl_q, out_fl_d;
    logic in_q, in_d, out0_q, out0_d, out1_q, out1_d;
    logic entry_open_q, exit_open_q, denied_q, route_q, route_d;

`ifdef PARKING_GATE_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(OPEN_TIMEOUT - 1);
    logic [TMO_W-1:0] e_tmo_q, e_tmo_d, x_tmo_q, x_tmo_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_tmo_q <= '0;
            x_tmo_q <= '0;
        end else begin
            e_tmo_q <= e_tmo_d;
            x_tmo_q <= x_tmo_d;
        end
    end
`endif

    // Entry barrier FSM
    always_comb begin
        e_state_d = e_state_q;
        in_req_c  = 1'b0;
`ifdef PARKING_GATE_TIMEOUT_EN
        e_tmo_d   = e_tmo_q;
`endif
        unique case (e_state_q)
            E_IDLE:  if (car_db) e_state_d = E_CHECK;
            E_CHECK: begin
                e_state_d = full ? E_DENY : E_OPEN;
`ifdef PARKING_GATE_TIMEOUT_EN
                e_tmo_d   = TMO_LOAD;
`endif
            end
            E_OPEN: begin
                if (epass_db) e_state_d = E_PASS;
`ifdef PARKING_GATE_TIMEOUT_EN
                else if (e_tmo_q == '0) e_state_d = E_IDLE;
                else e_tmo_d = e_tmo_q - TMO_W'(1);
`endif
            end
            E_PASS: begin
                if (!epass_db) begin
                    in_req_c  = 1'b1;
                    e_state_d = E_IDLE;
                end
            end
            E_DENY:  if (!car_db || !full) e_state_d = E_IDLE;
            default: e_state_d = E_IDLE;
        endcase
    end

    // Exit barrier FSM; floor granted round-robin when both request
    always_comb begin
        x_state_d = x_state_q;
        x_floor_d = x_floor_q;
        rr_d      = rr_q;
        out_req_c = 1'b0;
`ifdef PARKING_GATE_TIMEOUT_EN
        x_tmo_d   = x_tmo_q;
`endif
        unique case (x_state_q)
            X_IDLE: begin
                if (x0_db || x1_db) begin
                    x_state_d = X_OPEN;
                    x_floor_d = (x0_db && x1_db) ? rr_q : x1_db;
                    rr_d      = ~x_floor_d;
`ifdef PARKING_GATE_TIMEOUT_EN
                    x_tmo_d   = TMO_LOAD;
`endif
                end
            end
            X_OPEN: begin
                if (xpass_db) x_state_d = X_PASS;
`ifdef PARKING_GATE_TIMEOUT_EN
                else if (x_tmo_q == '0) x_state_d = X_IDLE;
                else x_tmo_d = x_tmo_q - TMO_W'(1);
`endif
            end
            X_PASS: begin
                if (!xpass_db) begin
                    out_req_c = 1'b1;
                    x_state_d = X_IDLE;
                end
            end
            default: x_state_d = X_IDLE;
        endcase
    end

    // Pulse scheduler: a pulse only follows an all-low cycle, entry wins ties
    always_comb begin
        in_d       = 1'b0;
        out0_d     = 1'b0;
        out1_d     = 1'b0;
        in_pend_d  = in_pend_q | in_req_c;
        out_pend_d = out_pend_q | out_req_c;
        out_fl_d   = out_req_c ? x_floor_q : out_fl_q;
        if (!(in_q || out0_q || out1_q)) begin
            if (in_pend_d) begin
                in_d      = 1'b1;
                in_pend_d = 1'b0;
            end else if (out_pend_d) begin
                out0_d     = ~out_fl_d;
                out1_d     = out_fl_d;
                out_pend_d = 1'b0;
            end
        end
    end

    always_comb begin
        route_d = route_q;
        if (floor0)      route_d = 1'b0;
        else if (floor1) route_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_state_q    <= E_IDLE;
            x_state_q    <= X_IDLE;
            x_floor_q    <= 1'b0;
            rr_q         <= 1'b0;
            in_pend_q    <= 1'b0;
            out_pend_q   <= 1'b0;
            out_fl_q     <= 1'b0;
            in_q         <= 1'b0;
            out0_q       <= 1'b0;
            out1_q       <= 1'b0;
            entry_open_q <= 1'b0;
            exit_open_q  <= 1'b0;
            denied_q     <= 1'b0;
            route_q      <= 1'b0;
        end else begin
            e_state_q    <= e_state_d;
            x_state_q    <= x_state_d;
            x_floor_q    <= x_floor_d;
            rr_q         <= rr_d;
            in_pend_q    <= in_pend_d;
            out_pend_q   <= out_pend_d;
            out_fl_q     <= out_fl_d;
            in_q         <= in_d;
            out0_q       <= out0_d;
            out1_q       <= out1_d;
            entry_open_q <= (e_state_d == E_OPEN) || (e_state_d == E_PASS);
            exit_open_q  <= (x_state_d == X_OPEN) || (x_state_d == X_PASS);
            denied_q     <= (e_state_d == E_DENY);
            route_q      <= route_d;
        end
    end

    assign in          = in_q;
    assign out0        = out0_q;
    assign out1        = out1_q;
    assign entry_open  = entry_open_q;
    assign exit_open   = exit_open_q;
    assign denied      = denied_q;
    assign route_floor = route_q;

endmodule

// File: tb/tb_parking_gate.sv
// Directed bench for parking_gate: per-cycle protocol/route model plus
// scenario-level expected pulse sequence and hand-computed latencies.
module tb_parking_gate;

    localparam int unsigned DEB = 2;
`ifdef PARKING_GATE_TIMEOUT_EN
    localparam int unsigned TB_TMO = 8;
`else
    localparam int unsigned TB_TMO = 1000;
`endif

    localparam int S_IN = 0, S_OUT0 = 1, S_OUT1 = 2, S_EOPEN = 3, S_XOPEN = 4, S_DENIED = 5;

    logic clk, rst;
    logic car_arrive, entry_passed, exit0_req, exit1_req, exit_passed;
    logic full, floor0, floor1;
    logic in, out0, out1, entry_open, exit_open, route_floor, denied;

    parking_gate #(.DEBOUNCE_CYCLES(DEB), .OPEN_TIMEOUT(TB_TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .car_arrive   (car_arrive),
        .entry_passed (entry_passed),
        .exit0_req    (exit0_req),
        .exit1_req    (exit1_req),
        .exit_passed  (exit_passed),
        .full         (full),
        .floor0       (floor0),
        .floor1       (floor1),
        .in           (in),
        .out0         (out0),
        .out1         (out1),
        .entry_open   (entry_open),
        .exit_open    (exit_open),
        .route_floor  (route_floor),
        .denied       (denied)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int exp_q[$];
    int cyc = 0;
    int last_in_cyc = 0;
    int last_out_cyc = 0;
    logic prev_any = 1'b0;
    logic exp_route = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            S_IN:     return in;
            S_OUT0:   return out0;
            S_OUT1:   return out1;
            S_EOPEN:  return entry_open;
            S_XOPEN:  return exit_open;
            S_DENIED: return denied;
            default:  return route_floor;
        endcase
    endfunction

    // Returns number of rising edges until sig(sel)==val, bounded.
    task automatic wait_sig(input string name, input int sel, input logic val,
                            input int max_cyc, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (sig(sel) !== val && n < max_cyc);
        if (sig(sel) !== val) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: no event after %0d cycles", name, n);
        end
    endtask

    task automatic pass_beam(input logic ent, input logic ext, input logic clr_req);
        @(negedge clk);
        entry_passed = ent;
        exit_passed  = ext;
        if (clr_req) begin
            car_arrive = 1'b0;
            exit0_req  = 1'b0;
            exit1_req  = 1'b0;
        end
        repeat (3) @(negedge clk);
        entry_passed = 1'b0;
        exit_passed  = 1'b0;
    endtask

    // Per-cycle model: route_floor rule, pulse protocol, expected pulse order.
    initial begin
        logic f0, f1, r, any;
        int kind;
        forever begin
            @(posedge clk);
            f0 = floor0;
            f1 = floor1;
            r  = rst;
            #1;
            cyc++;
            if (r) begin
                exp_route = 1'b0;
                prev_any  = 1'b0;
                check("reset_outputs", {in, out0, out1, entry_open, exit_open, route_floor, denied}, 0);
            end else begin
                if (f0)      exp_route = 1'b0;
                else if (f1) exp_route = 1'b1;
                check("route_floor", route_floor, exp_route);
                check("pulse_onehot", ($countones({in, out0, out1}) <= 1), 1);
                check("deny_vs_open", denied & entry_open, 0);
                any = in | out0 | out1;
                if (any) begin
                    kind = in ? S_IN : (out0 ? S_OUT0 : S_OUT1);
                    if (in) last_in_cyc = cyc;
                    else    last_out_cyc = cyc;
                    check("pulse_gap", prev_any, 0);
                    check("pulse_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("pulse_kind", kind, exp_q.pop_front());
                end
                prev_any = any;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, cnt;
        rst = 1'b1;
        car_arrive = 0; entry_passed = 0; exit0_req = 0; exit1_req = 0; exit_passed = 0;
        full = 0; floor0 = 1; floor1 = 0;

        // Reset state
        @(posedge clk); #1;
        check("rst_in", in, 0);
        check("rst_out0", out0, 0);
        check("rst_out1", out1, 0);
        check("rst_entry_open", entry_open, 0);
        check("rst_exit_open", exit_open, 0);
        check("rst_denied", denied, 0);
        check("rst_route", route_floor, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // One-cycle glitch on car_arrive must be filtered
        car_arrive = 1'b1;
        @(negedge clk);
        car_arrive = 1'b0;
        cnt = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (entry_open || denied) cnt++;
        end
        check("glitch_filtered", cnt, 0);

        // Normal entry: open 1+DEB+3 edges after arrival, one in pulse
        @(negedge clk);
        car_arrive = 1'b1;
        wait_sig("entry_open_rise", S_EOPEN, 1'b1, 40, n);
        check("entry_open_latency", n, DEB + 4);
        check("entry_not_denied", denied, 0);
        exp_q.push_back(S_IN);
        pass_beam(1'b1, 1'b0, 1'b1);
        wait_sig("in_pulse", S_IN, 1'b1, 30, n);
        check("entry_closed_at_in", entry_open, 0);
        repeat (10) @(posedge clk);
        #1 check("entry_stays_closed", entry_open, 0);

        // Lot full: denied, no opening; full drops -> re-check and open
        @(negedge clk);
        full = 1'b1;
        car_arrive = 1'b1;
        wait_sig("denied_rise", S_DENIED, 1'b1, 40, n);
        check("denied_latency", n, DEB + 4);
        cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (entry_open || !denied) cnt++;
        end
        check("deny_held", cnt, 0);
        @(negedge clk);
        full = 1'b0;
        wait_sig("open_after_full", S_EOPEN, 1'b1, 20, n);
        check("open_after_full_latency", n, 3);
        check("denied_cleared", denied, 0);
        exp_q.push_back(S_IN);
        pass_beam(1'b1, 1'b0, 1'b1);
        wait_sig("in_pulse2", S_IN, 1'b1, 30, n);
        repeat (10) @(negedge clk);

        // Both exits requesting: floor 0 first, then floor 1
        exit0_req = 1'b1;
        exit1_req = 1'b1;
        wait_sig("exit_open_rise", S_XOPEN, 1'b1, 40, n);
        check("exit_open_latency", n, DEB + 3);
        exp_q.push_back(S_OUT0);
        pass_beam(1'b0, 1'b1, 1'b0);
        wait_sig("out0_pulse", S_OUT0, 1'b1, 30, n);
        check("exit_closed_at_out0", exit_open, 0);
        wait_sig("exit_reopen", S_XOPEN, 1'b1, 10, n);
        check("exit_reopen_latency", n, 1);
        exp_q.push_back(S_OUT1);
        pass_beam(1'b0, 1'b1, 1'b1);
        wait_sig("out1_pulse", S_OUT1, 1'b1, 30, n);
        cnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (exit_open) cnt++;
        end
        check("exit_idle_after_rr", cnt, 0);

        // Entry and exit finish together: in at t, out0 at t+2
        @(negedge clk);
        car_arrive = 1'b1;
        exit0_req = 1'b1;
        wait_sig("conc_entry_open", S_EOPEN, 1'b1, 40, n);
        check("conc_exit_open", exit_open, 1);
        exp_q.push_back(S_IN);
        exp_q.push_back(S_OUT0);
        pass_beam(1'b1, 1'b1, 1'b1);
        wait_sig("conc_in", S_IN, 1'b1, 30, n);
        wait_sig("conc_out0", S_OUT0, 1'b1, 10, n);
        @(posedge clk); #2;
        check("conc_out_minus_in", last_out_cyc - last_in_cyc, 2);
        repeat (10) @(negedge clk);

        // Open barrier with no car passing
        car_arrive = 1'b1;
        wait_sig("tmo_open", S_EOPEN, 1'b1, 40, n);
        @(negedge clk);
        car_arrive = 1'b0;
        cnt = 1;
`ifdef PARKING_GATE_TIMEOUT_EN
        repeat (40) begin
            @(posedge clk); #1;
            if (entry_open) cnt++;
        end
        check("timeout_open_cycles", cnt, TB_TMO);
`else
        repeat (1000) begin
            @(posedge clk); #1;
            if (entry_open) cnt++;
        end
        check("no_timeout_open_cycles", cnt, 1001);
        exp_q.push_back(S_IN);
        pass_beam(1'b1, 1'b0, 1'b1);
        wait_sig("late_in", S_IN, 1'b1, 30, n);
`endif
        repeat (10) @(negedge clk);

        // Reset while the car is under the entry barrier
        car_arrive = 1'b1;
        wait_sig("rst_case_open", S_EOPEN, 1'b1, 40, n);
        @(negedge clk);
        car_arrive = 1'b0;
        entry_passed = 1'b1;
        repeat (7) @(posedge clk);
        #1 check("open_before_rst", entry_open, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_rst_outputs", {in, out0, out1, entry_open, exit_open, route_floor, denied}, 0);
        @(negedge clk);
        entry_passed = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("no_in_after_rst", entry_open, 0);

        // route_floor: directed values
        floor0 = 1'b0; floor1 = 1'b1;
        @(posedge clk); #1 check("route_f1", route_floor, 1);
        @(negedge clk); floor1 = 1'b0;
        @(posedge clk); #1 check("route_hold", route_floor, 1);
        @(negedge clk); floor0 = 1'b1; floor1 = 1'b1;
        @(posedge clk); #1 check("route_f0_prio", route_floor, 0);
        @(negedge clk); floor0 = 1'b0; floor1 = 1'b0;
        @(posedge clk); #1 check("route_hold0", route_floor, 0);

        repeat (3) @(posedge clk);
        #2 check("all_pulses_seen", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
